// File: rtl/despreader_pkg.sv
// Shared definitions for the chip despreader.
// Holds the FSM state type, the code-table generator and the window geometry.
// The generator returns each code as a 32-bit vector with bit n = chip c_n.
// This matches the receive window, where w[0] holds the oldest chip.
package despreader_pkg;

  typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_e;

  localparam int unsigned NumSymbols = 16;
  localparam int unsigned ChipsPerSym = 32;

  // CHIP[0] as listed in text order, so bit 31 here holds c0.
  localparam logic [31:0] Chip0Listed = 32'b11011001110000110101001000101110;

  // Codes 1..7 rotate CHIP[0] right by 4k chips.
  // Codes 8..15 additionally invert every odd-indexed chip.
  function automatic logic [31:0] chip_code(input int unsigned k);
    logic [31:0] code;
    int unsigned base;
    int unsigned idx;
    base = k % 8;
    code = '0;
    for (int unsigned n = 0; n < 32; n++) begin
      idx = (n + 32 - 4 * base) % 32;
      code[n] = Chip0Listed[31 - idx];
      if ((k >= 8) && ((n % 2) == 1)) code[n] = ~code[n];
    end
    return code;
  endfunction

endpackage

// File: rtl/hamming32.sv
// Combinational Hamming distance between two 32-bit words.
// Ports:
//   i_a    - first operand (received chip window)
//   i_b    - second operand (reference code)
//   o_dist - popcount of i_a ^ i_b, range 0..32
module hamming32 (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [5:0]  o_dist
);

  logic [31:0] w_x;

  assign w_x = i_a ^ i_b;

  always_comb begin
    o_dist = '0;
    for (int i = 0; i < 32; i++) begin
      o_dist = o_dist + 6'(w_x[i]);
    end
  end

endmodule

// File: rtl/chip_despreader.sv
// Receive-side chip despreader.
// Aligns to the symbol-0 preamble, then decodes each 32-chip block to a 4-bit symbol.
// Decoding picks the code with minimum Hamming distance; on a tie the lowest index wins.
// Ports:
//   inClock        - system clock, rising edge
//   inReset        - asynchronous active-high reset
//   inChipValid    - inChip is valid this cycle
//   inChip         - hard-decision chip, c0 first
//   inFull         - outFIFO full flag
//   outSymbol      - decoded symbol, valid with outSymbolValid
//   outSymbolValid - one-cycle outFIFO write enable
//   outLock        - aligned and decoding
//   outError       - one-cycle pulse: block rejected while locked
//   outOverflow    - one-cycle pulse: symbol dropped because outFIFO was full
module chip_despreader
  import despreader_pkg::*;
#(
  parameter int unsigned MAX_DIST   = 6,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inChipValid,
  input  logic       inChip,
  input  logic       inFull,
  output logic [3:0] outSymbol,
  output logic       outSymbolValid,
  output logic       outLock,
  output logic       outError,
  output logic       outOverflow
);

  localparam logic [5:0] MaxDist = 6'(MAX_DIST);
  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);
  localparam logic [3:0] MissLim = 4'(MISS_LIMIT);

  state_e      r_state, w_state;
  logic [31:0] r_win, w_win;
  logic [5:0]  r_fill, w_fill;
  logic [4:0]  r_phase, w_phase;
  logic [3:0]  r_pre, w_pre;
  logic [3:0]  r_miss, w_miss;
  logic [3:0]  r_sym, w_sym;
  logic        r_valid, w_valid;
  logic        r_err, w_err;
  logic        r_ovf, w_ovf;

  logic [5:0]  w_dist [NumSymbols];
  logic [5:0]  w_min;
  logic [3:0]  w_best;
  logic        w_d0_ok;

  // All decisions look at the window including the chip arriving this cycle.
  assign w_win = inChipValid ? {inChip, r_win[31:1]} : r_win;

  for (genvar k = 0; k < NumSymbols; k++) begin : g_ham
    localparam logic [31:0] Code = chip_code(k);
    hamming32 u_ham (
      .i_a   (w_win),
      .i_b   (Code),
      .o_dist(w_dist[k])
    );
  end

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    w_min  = w_dist[0];
    w_best = '0;
    for (int k = 1; k < NumSymbols; k++) begin
      if (w_dist[k] < w_min) begin
        w_min  = w_dist[k];
        w_best = 4'(k);
      end
    end
  end

  assign w_d0_ok = (w_dist[0] <= MaxDist);

  always_comb begin
    w_state = r_state;
    w_fill  = r_fill;
    w_phase = r_phase;
    w_pre   = r_pre;
    w_miss  = r_miss;
    w_sym   = r_sym;
    w_valid = 1'b0;
    w_err   = 1'b0;
    w_ovf   = 1'b0;
    if (inChipValid) begin
      if (r_fill != 6'(ChipsPerSym)) w_fill = r_fill + 6'd1;
      w_phase = r_phase + 5'd1;
      unique case (r_state)
        SEARCH: begin
          // Sliding search: test every chip once the window is full.
          if ((w_fill == 6'(ChipsPerSym)) && w_d0_ok) begin
            w_pre   = 4'd1;
            w_phase = '0;
            w_state = (LockCnt == 4'd1) ? LOCKED : ALIGN;
          end
        end
        ALIGN: begin
          if (r_phase == 5'd31) begin
            if (w_d0_ok) begin
              w_pre = r_pre + 4'd1;
              if (w_pre == LockCnt) w_state = LOCKED;
            end else begin
              w_pre   = '0;
              w_fill  = '0;
              w_state = SEARCH;
            end
          end
        end
        LOCKED: begin
          if (r_phase == 5'd31) begin
            if (w_min <= MaxDist) begin
              w_miss = '0;
              if (inFull) begin
                w_ovf = 1'b1;
              end else begin
                w_valid = 1'b1;
                w_sym   = w_best;
              end
            end else begin
              w_err  = 1'b1;
              w_miss = r_miss + 4'd1;
              if (w_miss == MissLim) begin
                w_state = SEARCH;
                w_fill  = '0;
                w_miss  = '0;
                w_pre   = '0;
              end
            end
          end
        end
        default: w_state = SEARCH;
      endcase
    end
  end

  always_ff @(posedge inClock or posedge inReset) begin
    if (inReset) begin
      r_state <= SEARCH;
      r_win   <= '0;
      r_fill  <= '0;
      r_phase <= '0;
      r_pre   <= '0;
      r_miss  <= '0;
      r_sym   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_win   <= w_win;
      r_fill  <= w_fill;
      r_phase <= w_phase;
      r_pre   <= w_pre;
      r_miss  <= w_miss;
      r_sym   <= w_sym;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_ovf   <= w_ovf;
    end
  end

  assign outSymbol      = r_sym;
  assign outSymbolValid = r_valid;
  assign outLock        = (r_state == LOCKED);
  assign outError       = r_err;
  assign outOverflow    = r_ovf;

endmodule

// File: doc/chip_despreader.md
Name: chip_despreader

Overview:
- Receive-side counterpart of the transmit chip coder. It takes the hard-decision chip stream recovered by the CDR, one chip per strobe.
- It finds 32-chip symbol alignment on the preamble and despreads each 32-chip block to a 4-bit symbol by minimum Hamming distance.
- Decoded symbols are written to the outFIFO. The block sits between the CDR and the outFIFO.

Parameters:
- MAX_DIST, 6, largest Hamming distance (0..32) still accepted as a valid symbol.
- LOCK_COUNT, 4, number of consecutive aligned symbol-0 blocks needed to declare lock (1..15).
- MISS_LIMIT, 2, number of consecutive rejected blocks that drops lock (1..15).

Ports:
- inClock  in  1  system clock, rising edge.
- inReset  in  1  asynchronous, active-high reset.
- inChipValid  in  1  strobe: inChip is valid this cycle.
- inChip  in  1  chip value; the first chip of a symbol is c0.
- inFull  in  1  outFIFO full flag.
- outSymbol  out  4  decoded symbol, valid while outSymbolValid=1.
- outSymbolValid  out  1  one-cycle pulse; this is the outFIFO write enable.
- outLock  out  1  level: block is aligned and decoding.
- outError  out  1  one-cycle pulse: a block was rejected while locked.
- outOverflow  out  1  one-cycle pulse: a symbol was dropped because inFull=1.

Behaviour:
- Interface: one clock, inClock. Reset inReset is asynchronous and active-high.
- Reset state: shift window=0, chip count=0, state=SEARCH. outSymbol=0; outSymbolValid, outLock, outError, outOverflow all =0.
- Reset asserted mid-operation clears everything immediately, including any pending decision.
- Chip window:
  - 32-bit window w[0..31]; w[31] is the newest chip, w[0] the oldest.
  - A chip is shifted in only on edges where inChipValid=1.
  - When aligned, w[n] = c_n.
- Fill counter: counts accepted chips, saturating at 32. No comparisons are made until 32 chips have been received since reset or since a return to SEARCH.
- Distance: d_k = popcount(w XOR CHIP[k]) for k = 0..15.
  - Best symbol = argmin d_k; on a tie, the lowest k wins.
- All decisions are evaluated on the updated window. Outputs are registered and appear on the edge after the chip that completed the window, i.e. 1-cycle latency.
- State SEARCH (sliding):
  - After every accepted chip with fill=32, test d_0 ≤ MAX_DIST.
  - Hit: pre count=1, chip phase=0, go to ALIGN. If LOCK_COUNT=1, go directly to LOCKED.
- State ALIGN:
  - Chip phase counts 0..31 and wraps. Tests are made only when the phase wraps, i.e. at each 32nd chip.
  - d_0 ≤ MAX_DIST: pre count++. When pre count reaches LOCK_COUNT, go to LOCKED and set outLock=1.
  - Otherwise: pre count=0, fill=0, go to SEARCH.
  - Preamble blocks are never output.
- State LOCKED:
  - At each 32-chip boundary, evaluate the best symbol.
  - min d ≤ MAX_DIST and inFull=0: outSymbol=k, outSymbolValid=1, miss=0.
  - min d ≤ MAX_DIST and inFull=1: outOverflow=1, no write, miss=0.
  - min d > MAX_DIST: outError=1, miss++. When miss reaches MISS_LIMIT, go to SEARCH with outLock=0, fill=0, miss=0. outLock falls on the same edge as the last outError.
- Symbol-0 blocks received while LOCKED are decoded and output like any other symbol.
- A chip arriving on the cycle right after a boundary is accepted normally. There is no dead cycle; back-to-back inChipValid every cycle must be supported.

Decomposition:
- Package despreader_pkg holds:
  - CHIP[0] = 11011001110000110101001000101110, c0 listed first.
  - For k = 1..7: CHIP[k][n] = CHIP[0][(n−4k) mod 32], i.e. a right rotation by 4k chips.
  - CHIP[k+8][n] = CHIP[k][n] XOR (n odd).
  - The state enum {SEARCH, ALIGN, LOCKED}.
- One sub-module, hamming32: a combinational popcount of a 32-bit XOR, producing a 6-bit result. It is instantiated 16 times, followed by a min/argmin tree in the top module.

Test Plan:
- Reset, then 4×CHIP[0] back-to-back with inChipValid=1 every cycle.
  - outLock rises exactly 1 cycle after the 128th chip.
  - No outSymbolValid.
- Locked, then send CHIP[7] followed by CHIP[12].
  - outSymbol=7, then 12.
  - Each outSymbolValid pulse comes 1 cycle after the 32nd chip of its block.
- Locked, send CHIP[9] with chips 0, 15 and 31 inverted (d=3).
  - outSymbol=9.
  - Repeat with 7 inversions: outError pulse, no write.
- Locked, send 2 blocks of 32 zero chips (d ≥ 8 for all k).
  - Two outError pulses.
  - outLock falls with the second pulse.
  - Then 5 zero chips followed by 4×CHIP[0] relocks, with outLock high after the last chip + 1.
- inChipValid toggling 1-in-3 cycles with inFull=1 during one CHIP[3] block.
  - outOverflow pulse, no outSymbolValid.
  - The next block with inFull=0 gives outSymbol=3.
- Assert inReset asynchronously mid-block while LOCKED.
  - All outputs are 0 immediately, without waiting for a clock edge.
  - After release, no output until a fresh lock is acquired.
